// File: rtl/cursor_ctrl_pkg.sv
// rtl/cursor_ctrl_pkg.sv - opcodes, FSM state encoding and tab width for the cursor controller
//
// Shared constants only; no ports.

package cursor_ctrl_pkg;

    // Command opcodes from the escape-sequence decoder. Codes 12-15 act as NOP.
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_UP    = 4'd1;
    localparam logic [3:0] OP_DOWN  = 4'd2;
    localparam logic [3:0] OP_RIGHT = 4'd3;
    localparam logic [3:0] OP_LEFT  = 4'd4;
    localparam logic [3:0] OP_HOME  = 4'd5;
    localparam logic [3:0] OP_CR    = 4'd6;
    localparam logic [3:0] OP_LF    = 4'd7;
    localparam logic [3:0] OP_BS    = 4'd8;
    localparam logic [3:0] OP_TAB   = 4'd9;
    localparam logic [3:0] OP_ADDR  = 4'd10;
    localparam logic [3:0] OP_RLF   = 4'd11;

    // Sequencer states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    // Horizontal tab stop spacing; must be a power of two.
    localparam int TAB_WIDTH = 8;

endpackage

// File: rtl/cursor_next_pos.sv
// rtl/cursor_next_pos.sv - combinational next-position calculator for one cursor command
//
// Ports:
//   op_i          opcode
//   cur_x_i/y_i   current cursor column/row
//   arg_x_i/y_i   ADDR target column/row
//   next_x_o/y_o  resulting column/row
//   wen_o         a position write is required
//   scroll_o      the command needs a scroll instead of a write
//   scroll_dir_o  0 = scroll up (LF), 1 = scroll down (RLF)

module cursor_next_pos
    import cursor_ctrl_pkg::*;
#(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7,
    parameter int ROWS     = 24,
    parameter int COLS     = 80
) (
    input  logic [3:0]          op_i,
    input  logic [COL_BITS-1:0] cur_x_i,
    input  logic [ROW_BITS-1:0] cur_y_i,
    input  logic [COL_BITS-1:0] arg_x_i,
    input  logic [ROW_BITS-1:0] arg_y_i,
    output logic [COL_BITS-1:0] next_x_o,
    output logic [ROW_BITS-1:0] next_y_o,
    output logic                wen_o,
    output logic                scroll_o,
    output logic                scroll_dir_o
);

    // All comparisons and arithmetic happen at integer width so an
    // increment or decrement can never wrap back into range.
    int x_w;
    int y_w;
    int ax_w;
    int ay_w;
    int tab_w;

    assign x_w   = int'(cur_x_i);
    assign y_w   = int'(cur_y_i);
    assign ax_w  = int'(arg_x_i);
    assign ay_w  = int'(arg_y_i);
    // Round down to the current stop, then step one stop forward.
    assign tab_w = (x_w & ~(TAB_WIDTH - 1)) + TAB_WIDTH;

    always_comb begin
        next_x_o     = cur_x_i;
        next_y_o     = cur_y_i;
        wen_o        = 1'b0;
        scroll_o     = 1'b0;
        scroll_dir_o = 1'b0;
        case (op_i)
            OP_UP: begin
                wen_o = 1'b1;
                if (y_w > 0) next_y_o = ROW_BITS'(y_w - 1);
            end
            OP_DOWN: begin
                wen_o = 1'b1;
                if (y_w < ROWS - 1) next_y_o = ROW_BITS'(y_w + 1);
            end
            OP_RIGHT: begin
                wen_o = 1'b1;
                if (x_w < COLS - 1) next_x_o = COL_BITS'(x_w + 1);
            end
            OP_LEFT, OP_BS: begin
                wen_o = 1'b1;
                if (x_w > 0) next_x_o = COL_BITS'(x_w - 1);
            end
            OP_HOME: begin
                wen_o    = 1'b1;
                next_x_o = '0;
                next_y_o = '0;
            end
            OP_CR: begin
                wen_o    = 1'b1;
                next_x_o = '0;
            end
            OP_LF: begin
                if (y_w < ROWS - 1) begin
                    wen_o    = 1'b1;
                    next_y_o = ROW_BITS'(y_w + 1);
                end else begin
                    scroll_o = 1'b1;
                end
            end
            OP_RLF: begin
                if (y_w > 0) begin
                    wen_o    = 1'b1;
                    next_y_o = ROW_BITS'(y_w - 1);
                end else begin
                    scroll_o     = 1'b1;
                    scroll_dir_o = 1'b1;
                end
            end
            OP_TAB: begin
                wen_o = 1'b1;
                if (x_w < COLS - 1) begin
                    next_x_o = (tab_w > COLS - 1) ? COL_BITS'(COLS - 1) : COL_BITS'(tab_w);
                end
            end
            OP_ADDR: begin
                wen_o = 1'b1;
                if (ay_w < ROWS) next_y_o = arg_y_i;
                next_x_o = (ax_w >= COLS) ? COL_BITS'(COLS - 1) : arg_x_i;
            end
            default: begin
                // NOP and reserved codes: nothing to do.
            end
        endcase
    end

endmodule

// File: rtl/cursor_controller.sv
// rtl/cursor_controller.sv - command sequencer between escape decoder and cursor/scroll blocks
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cmd_valid/ready       command handshake (ready only in IDLE)
//   cmd_op, cmd_arg_x/y   opcode and ADDR arguments
//   cursor_x/y            current position from the cursor block
//   new_cursor_x/y/wen    registered position write port
//   scroll_req/dir/ack    scroll request to the scroll controller

module cursor_controller
    import cursor_ctrl_pkg::*;
#(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7,
    parameter int ROWS     = 24,
    parameter int COLS     = 80
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [COL_BITS-1:0] cmd_arg_x,
    input  logic [ROW_BITS-1:0] cmd_arg_y,
    input  logic [COL_BITS-1:0] cursor_x,
    input  logic [ROW_BITS-1:0] cursor_y,
    output logic [COL_BITS-1:0] new_cursor_x,
    output logic [ROW_BITS-1:0] new_cursor_y,
    output logic                new_cursor_wen,
    output logic                scroll_req,
    output logic                scroll_dir,
    input  logic                scroll_ack
);

    logic [1:0]          state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [COL_BITS-1:0] arg_x_q, arg_x_d;
    logic [ROW_BITS-1:0] arg_y_q, arg_y_d;
    logic [COL_BITS-1:0] new_x_q, new_x_d;
    logic [ROW_BITS-1:0] new_y_q, new_y_d;
    logic                wen_q, wen_d;
    logic                req_q, req_d;
    logic                dir_q, dir_d;

    logic [COL_BITS-1:0] np_x;
    logic [ROW_BITS-1:0] np_y;
    logic                np_wen;
    logic                np_scroll;
    logic                np_dir;

    // The current position is read in EXEC, one cycle after acceptance, so a
    // write issued by the previous command has already landed in the cursor block.
    cursor_next_pos #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) u_next_pos (
        .op_i         (op_q),
        .cur_x_i      (cursor_x),
        .cur_y_i      (cursor_y),
        .arg_x_i      (arg_x_q),
        .arg_y_i      (arg_y_q),
        .next_x_o     (np_x),
        .next_y_o     (np_y),
        .wen_o        (np_wen),
        .scroll_o     (np_scroll),
        .scroll_dir_o (np_dir)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_x_d = arg_x_q;
        arg_y_d = arg_y_q;
        new_x_d = new_x_q;
        new_y_d = new_y_q;
        wen_d   = 1'b0;
        req_d   = req_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    arg_x_d = cmd_arg_x;
                    arg_y_d = cmd_arg_y;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (np_wen) begin
                    new_x_d = np_x;
                    new_y_d = np_y;
                    wen_d   = 1'b1;
                end
                if (np_scroll) begin
                    req_d   = 1'b1;
                    dir_d   = np_dir;
                    state_d = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (scroll_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            arg_x_q <= '0;
            arg_y_q <= '0;
            new_x_q <= '0;
            new_y_q <= '0;
            wen_q   <= 1'b0;
            req_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_x_q <= arg_x_d;
            arg_y_q <= arg_y_d;
            new_x_q <= new_x_d;
            new_y_q <= new_y_d;
            wen_q   <= wen_d;
            req_q   <= req_d;
            dir_q   <= dir_d;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign new_cursor_x   = new_x_q;
    assign new_cursor_y   = new_y_q;
    assign new_cursor_wen = wen_q;
    assign scroll_req     = req_q;
    assign scroll_dir     = dir_q;

endmodule

// File: tb/tb_cursor_controller.sv
// tb/tb_cursor_controller.sv - randomized self-checking bench for cursor_controller

module tb_cursor_controller;

    localparam int ROWS = 24;
    localparam int COLS = 80;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [6:0] cmd_arg_x;
    logic [4:0] cmd_arg_y;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic [6:0] new_cursor_x;
    logic [4:0] new_cursor_y;
    logic       new_cursor_wen;
    logic       scroll_req;
    logic       scroll_dir;
    logic       scroll_ack;

    int n_checks = 0;
    int n_fails  = 0;

    // Position held by the emulated cursor block.
    int mdl_x;
    int mdl_y;

    cursor_controller #(
        .ROW_BITS (5),
        .COL_BITS (7),
        .ROWS     (ROWS),
        .COLS     (COLS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg_x      (cmd_arg_x),
        .cmd_arg_y      (cmd_arg_y),
        .cursor_x       (cursor_x),
        .cursor_y       (cursor_y),
        .new_cursor_x   (new_cursor_x),
        .new_cursor_y   (new_cursor_y),
        .new_cursor_wen (new_cursor_wen),
        .scroll_req     (scroll_req),
        .scroll_dir     (scroll_dir),
        .scroll_ack     (scroll_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour straight from the command rules.
    function automatic void ref_next(input int op, input int cx, input int cy,
                                     input int ax, input int ay,
                                     output int ex, output int ey,
                                     output bit w, output bit s, output bit d);
        ex = cx; ey = cy; w = 0; s = 0; d = 0;
        case (op)
            1:  begin w = 1; if (cy > 0) ey = cy - 1; end
            2:  begin w = 1; if (cy < ROWS - 1) ey = cy + 1; end
            3:  begin w = 1; if (cx < COLS - 1) ex = cx + 1; end
            4, 8: begin w = 1; if (cx > 0) ex = cx - 1; end
            5:  begin w = 1; ex = 0; ey = 0; end
            6:  begin w = 1; ex = 0; end
            7:  if (cy < ROWS - 1) begin w = 1; ey = cy + 1; end else s = 1;
            9:  begin
                    w = 1;
                    if (cx < COLS - 1) begin
                        int t = cx + 1;
                        while (t % 8 != 0) t++;
                        ex = (t > COLS - 1) ? COLS - 1 : t;
                    end
                end
            10: begin
                    w = 1;
                    if (ay < ROWS) ey = ay;
                    ex = (ax >= COLS) ? COLS - 1 : ax;
                end
            11: if (cy > 0) begin w = 1; ey = cy - 1; end else begin s = 1; d = 1; end
            default: ;
        endcase
    endfunction

    // One full command: accept, EXEC, result; for scrolls, hold cmd_valid
    // for ack_delay cycles and then acknowledge.
    task automatic do_cmd(input int op, input int ax, input int ay, input int ack_delay);
        int ex, ey;
        bit w, s, d;
        ref_next(op, mdl_x, mdl_y, ax, ay, ex, ey, w, s, d);
        @(negedge clk);
        cursor_x  = 7'(mdl_x);
        cursor_y  = 5'(mdl_y);
        cmd_op    = 4'(op);
        cmd_arg_x = 7'(ax);
        cmd_arg_y = 5'(ay);
        cmd_valid = 1'b1;
        check_eq("ready_idle", int'(cmd_ready), 1);
        check_eq("wen_idle", int'(new_cursor_wen), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_arg_x = 7'($urandom);
        cmd_arg_y = 5'($urandom);
        check_eq("ready_exec", int'(cmd_ready), 0);
        check_eq("wen_exec", int'(new_cursor_wen), 0);
        @(negedge clk);
        if (s) begin
            check_eq("scroll_req_rise", int'(scroll_req), 1);
            check_eq("scroll_dir", int'(scroll_dir), int'(d));
            check_eq("scroll_no_wen", int'(new_cursor_wen), 0);
            check_eq("ready_scroll", int'(cmd_ready), 0);
            cmd_valid = 1'b1;
            cmd_op    = 4'd3;
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk);
                check_eq("ready_wait", int'(cmd_ready), 0);
                check_eq("req_wait", int'(scroll_req), 1);
            end
            scroll_ack = 1'b1;
            @(negedge clk);
            scroll_ack = 1'b0;
            cmd_valid  = 1'b0;
            check_eq("req_after_ack", int'(scroll_req), 0);
            check_eq("ready_after_ack", int'(cmd_ready), 1);
            check_eq("wen_after_ack", int'(new_cursor_wen), 0);
        end else if (w) begin
            check_eq("wen_pulse", int'(new_cursor_wen), 1);
            check_eq("new_x", int'(new_cursor_x), ex);
            check_eq("new_y", int'(new_cursor_y), ey);
            check_eq("ready_back", int'(cmd_ready), 1);
            check_eq("no_scroll", int'(scroll_req), 0);
            mdl_x = ex;
            mdl_y = ey;
        end else begin
            check_eq("nop_wen", int'(new_cursor_wen), 0);
            check_eq("nop_scroll", int'(scroll_req), 0);
            check_eq("nop_ready", int'(cmd_ready), 1);
        end
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 4'd0;
        cmd_arg_x  = 7'd0;
        cmd_arg_y  = 5'd0;
        cursor_x   = 7'd0;
        cursor_y   = 5'd0;
        scroll_ack = 1'b0;
        mdl_x = 0;
        mdl_y = 0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", int'(cmd_ready), 1);
        check_eq("rst_wen", int'(new_cursor_wen), 0);
        check_eq("rst_x", int'(new_cursor_x), 0);
        check_eq("rst_y", int'(new_cursor_y), 0);
        check_eq("rst_req", int'(scroll_req), 0);
        check_eq("rst_dir", int'(scroll_dir), 0);
        reset = 1'b1;

        // Edges of the screen.
        mdl_x = 79; mdl_y = 5;
        do_cmd(3, 0, 0, 0);
        mdl_x = 0;
        do_cmd(4, 0, 0, 0);

        // Tab stops across a full line.
        mdl_x = 0;
        for (int i = 0; i < 11; i++) begin
            do_cmd(9, 0, 0, 0);
            check_eq("tab_stop", mdl_x, (i < 9) ? (i + 1) * 8 : 79);
        end

        // Out-of-range and in-range ADDR.
        mdl_x = 10; mdl_y = 3;
        do_cmd(10, 100, 30, 0);
        do_cmd(10, 5, 23, 0);

        // LF at the bottom, RLF at the top and in the middle.
        do_cmd(7, 0, 0, 5);
        do_cmd(7, 0, 0, 0);
        mdl_y = 0;
        do_cmd(11, 0, 0, 2);
        mdl_y = 4;
        do_cmd(11, 0, 0, 0);
        check_eq("rlf_row", mdl_y, 3);

        // Reset while waiting for a scroll ack.
        mdl_y = 0;
        @(negedge clk);
        cursor_x = 7'(mdl_x); cursor_y = 5'(mdl_y);
        cmd_op = 4'd11; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_req", int'(scroll_req), 1);
        reset = 1'b0;
        #1;
        check_eq("rst_scroll_req", int'(scroll_req), 0);
        check_eq("rst_scroll_dir", int'(scroll_dir), 0);
        check_eq("rst_scroll_ready", int'(cmd_ready), 1);
        check_eq("rst_scroll_x", int'(new_cursor_x), 0);
        @(negedge clk);
        reset = 1'b1;
        scroll_ack = 1'b1;
        @(negedge clk);
        scroll_ack = 1'b0;
        check_eq("late_ack_req", int'(scroll_req), 0);
        check_eq("late_ack_ready", int'(cmd_ready), 1);

        // Reset during EXEC drops the pending write.
        mdl_x = 20; mdl_y = 7;
        @(negedge clk);
        cursor_x = 7'(mdl_x); cursor_y = 5'(mdl_y);
        cmd_op = 4'd3; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("rst_exec_wen", int'(new_cursor_wen), 0);
        @(negedge clk);
        check_eq("rst_exec_wen2", int'(new_cursor_wen), 0);
        check_eq("rst_exec_ready", int'(cmd_ready), 1);

        // Random traffic with the bench acting as the cursor block.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                mdl_x = $urandom_range(0, COLS - 1);
                mdl_y = $urandom_range(0, ROWS - 1);
            end
            do_cmd($urandom_range(0, 15), $urandom_range(0, 127),
                   $urandom_range(0, 31), $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
